// File: rtl/uart_instr_loader.sv
// UART byte stream to instruction-word FIFO.
// Little-endian word assembly with idle timeout and a first-word fall-through queue.
module uart_instr_loader #(
    parameter int INSTR_BYTES    = 4,
    parameter int INSTR_WIDTH    = 32,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx_valid,
    input  logic [7:0]                   rx_data,
    input  logic                         re,
    output logic [INSTR_WIDTH-1:0]       instr_out,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         frame_err,
    input  logic                         clear_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        IDLE,
        ASSEMBLE
    } state_t;

    state_t                 state, state_n;
    logic [BW-1:0]          byte_idx, byte_idx_n;
    logic [INSTR_WIDTH-1:0] lanes, lanes_n;
    logic [TW-1:0]          idle_cnt, idle_cnt_n;
    logic                   word_done;
    logic                   timeout;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic                   push, pop, drop;

    always_comb begin
        state_n    = state;
        byte_idx_n = byte_idx;
        lanes_n    = lanes;
        idle_cnt_n = '0;
        word_done  = 1'b0;
        timeout    = 1'b0;
        if (rx_valid) begin
            lanes_n[{byte_idx, 3'b000} +: 8] = rx_data;
            if (byte_idx == BW'(INSTR_BYTES - 1)) begin
                word_done  = 1'b1;
                byte_idx_n = '0;
                state_n    = IDLE;
            end else begin
                byte_idx_n = byte_idx + 1'b1;
                state_n    = ASSEMBLE;
            end
        end else if (state == ASSEMBLE) begin
            // a byte arriving on the expiry cycle takes priority above
            if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                timeout    = 1'b1;
                lanes_n    = '0;
                byte_idx_n = '0;
                state_n    = IDLE;
            end else begin
                idle_cnt_n = idle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            byte_idx <= '0;
            lanes    <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_n;
            byte_idx <= byte_idx_n;
            lanes    <= lanes_n;
            idle_cnt <= idle_cnt_n;
        end
    end

    assign pop  = re && !empty;
    assign push = word_done && (!full || re);
    assign drop = word_done && full && !re;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= lanes_n;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (drop)           overflow <= 1'b1;
            else if (clear_err) overflow <= 1'b0;
            if (timeout)        frame_err <= 1'b1;
            else if (clear_err) frame_err <= 1'b0;
        end
    end

    assign instr_out = mem[rd_ptr];
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));

endmodule

// File: tb/tb_uart_instr_loader.sv
// Directed and scoreboard tests for uart_instr_loader.
// DEPTH=16, TIMEOUT_CYCLES=20.
module tb_uart_instr_loader;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        re;
    logic [31:0] instr_out;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        overflow;
    logic        frame_err;
    logic        clear_err;

    int checks = 0;
    int errors = 0;

    uart_instr_loader #(
        .INSTR_BYTES(4),
        .INSTR_WIDTH(32),
        .DEPTH(16),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .re(re),
        .instr_out(instr_out),
        .empty(empty),
        .full(full),
        .count(count),
        .overflow(overflow),
        .frame_err(frame_err),
        .clear_err(clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8]);
    endtask

    task automatic pop_one();
        re = 1'b1;
        tick();
        re = 1'b0;
    endtask

    task automatic clear_flags();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        re = 1'b0;
        clear_err = 1'b0;
        #12;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL reset_occ: empty=%b full=%b count=%0d want 1 0 0", empty, full, count);
        end
        checks++;
        if (instr_out !== 32'h0 || overflow !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: instr=%h ovf=%b ferr=%b want 0 0 0", instr_out, overflow, frame_err);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_word();
        send_byte(8'h11); idle(9);
        send_byte(8'h22); idle(9);
        send_byte(8'h33); idle(9);
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL single_partial_empty: empty=%b want 1", empty);
        end
        send_byte(8'h44);
        checks++;
        if (instr_out !== 32'h44332211 || empty !== 1'b0 || count !== 5'd1) begin
            errors++;
            $display("FAIL single_word: instr=%h empty=%b count=%0d want 44332211 0 1", instr_out, empty, count);
        end
        pop_one();
        checks++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            errors++;
            $display("FAIL single_pop: empty=%b count=%0d want 1 0", empty, count);
        end
    endtask

    task automatic test_full_overflow();
        logic [31:0] w [16];
        logic [31:0] w17;
        w17 = 32'hDEAD0017;
        for (int i = 0; i < 16; i++) begin
            w[i] = 32'h01020304 + 32'(i) * 32'h11111111;
            send_word(w[i]);
        end
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0 || instr_out !== w[0]) begin
            errors++;
            $display("FAIL fill: full=%b count=%0d ovf=%b instr=%h want 1 16 0 %h", full, count, overflow, instr_out, w[0]);
        end
        send_word(w17);
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1 || instr_out !== w[0]) begin
            errors++;
            $display("FAIL overflow: full=%b count=%0d ovf=%b instr=%h want 1 16 1 %h", full, count, overflow, instr_out, w[0]);
        end
        clear_flags();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: ovf=%b want 0", overflow);
        end
        for (int k = 0; k < 3; k++) send_byte(w17[k*8 +: 8]);
        rx_valid = 1'b1;
        rx_data  = w17[31:24];
        re       = 1'b1;
        tick();
        rx_valid = 1'b0;
        re       = 1'b0;
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0 || instr_out !== w[1]) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d ovf=%b instr=%h want 16 0 %h", count, overflow, instr_out, w[1]);
        end
        for (int i = 1; i < 16; i++) begin
            checks++;
            if (instr_out !== w[i]) begin
                errors++;
                $display("FAIL drain_%0d: instr=%h want %h", i, instr_out, w[i]);
            end
            pop_one();
        end
        checks++;
        if (instr_out !== w17 || count !== 5'd1) begin
            errors++;
            $display("FAIL drain_last: instr=%h count=%0d want %h 1", instr_out, count, w17);
        end
        pop_one();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: empty=%b want 1", empty);
        end
    endtask

    task automatic test_timeout();
        send_byte(8'hEE);
        send_byte(8'hFF);
        idle(19);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: ferr=%b want 0", frame_err);
        end
        idle(1);
        checks++;
        if (frame_err !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire: ferr=%b empty=%b want 1 1", frame_err, empty);
        end
        send_word(32'hDDCCBBAA);
        checks++;
        if (instr_out !== 32'hDDCCBBAA || count !== 5'd1) begin
            errors++;
            $display("FAIL timeout_resync: instr=%h count=%0d want ddccbbaa 1", instr_out, count);
        end
        clear_flags();
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL frame_clear: ferr=%b want 0", frame_err);
        end
        pop_one();
    endtask

    task automatic test_back_to_back();
        logic [31:0] y;
        y = 32'hCAFEF00D;
        send_word(32'h12345678);
        for (int k = 0; k < 3; k++) begin
            send_byte(y[k*8 +: 8]);
            checks++;
            if (empty !== 1'b0) begin
                errors++;
                $display("FAIL b2b_hold_%0d: empty=%b want 0", k, empty);
            end
        end
        rx_valid = 1'b1;
        rx_data  = y[31:24];
        re       = 1'b1;
        tick();
        rx_valid = 1'b0;
        re       = 1'b0;
        checks++;
        if (count !== 5'd1 || empty !== 1'b0 || instr_out !== y) begin
            errors++;
            $display("FAIL b2b: count=%0d empty=%b instr=%h want 1 0 %h", count, empty, instr_out, y);
        end
        pop_one();
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] cur;
        int          sent;
        int          bidx;
        int          gap;
        int          cyc;
        logic        do_push;
        logic        do_pop;
        sent = 0;
        bidx = 0;
        gap  = 0;
        cyc  = 0;
        cur  = $urandom();
        while ((sent < 40 || q.size() > 0) && cyc < 3000) begin
            cyc++;
            rx_valid = 1'b0;
            re       = 1'b0;
            if (sent < 40) begin
                if (gap > 0) gap--;
                else begin
                    rx_valid = 1'b1;
                    rx_data  = cur[bidx*8 +: 8];
                end
            end
            if (empty) re = ($urandom_range(0, 3) == 0);
            else       re = ($urandom_range(0, 1) == 1);
            checks++;
            if (empty !== (q.size() == 0)) begin
                errors++;
                $display("FAIL rand_empty: empty=%b want %b", empty, q.size() == 0);
            end
            do_pop  = re && (q.size() > 0);
            do_push = rx_valid && (bidx == 3);
            if (do_pop) begin
                checks++;
                if (instr_out !== q[0]) begin
                    errors++;
                    $display("FAIL rand_data: instr=%h want %h", instr_out, q[0]);
                end
                void'(q.pop_front());
            end
            if (do_push && q.size() < 16) q.push_back(cur);
            if (rx_valid) begin
                bidx++;
                if (bidx == 4) begin
                    bidx = 0;
                    sent++;
                    cur = $urandom();
                end
                gap = $urandom_range(0, 3);
            end
            tick();
            checks++;
            if (count !== 5'(q.size())) begin
                errors++;
                $display("FAIL rand_count: count=%0d want %0d", count, q.size());
            end
        end
        rx_valid = 1'b0;
        re       = 1'b0;
        checks++;
        if (sent != 40 || q.size() != 0) begin
            errors++;
            $display("FAIL rand_budget: sent=%0d left=%0d want 40 0", sent, q.size());
        end
        re = 1'b1;
        idle(3);
        re = 1'b0;
        checks++;
        if (empty !== 1'b1 || count !== 5'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL re_when_empty: empty=%b count=%0d ovf=%b want 1 0 0", empty, count, overflow);
        end
    endtask

    task automatic test_reset_mid_word();
        send_byte(8'h5A);
        idle(20);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_ferr: ferr=%b want 1", frame_err);
        end
        send_word(32'h0A0B0C0D);
        send_word(32'h1A1B1C1D);
        send_word(32'h2A2B2C2D);
        send_byte(8'h77);
        send_byte(8'h88);
        reset = 1'b0;
        #2;
        checks++;
        if (empty !== 1'b1 || count !== 5'd0 || frame_err !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: empty=%b count=%0d ferr=%b ovf=%b want 1 0 0 0", empty, count, frame_err, overflow);
        end
        tick();
        reset = 1'b1;
        idle(25);
        checks++;
        if (frame_err !== 1'b0 || overflow !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: ferr=%b ovf=%b empty=%b want 0 0 1", frame_err, overflow, empty);
        end
        send_word(32'h87654321);
        checks++;
        if (instr_out !== 32'h87654321 || count !== 5'd1) begin
            errors++;
            $display("FAIL post_reset_word: instr=%h count=%0d want 87654321 1", instr_out, count);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_overflow();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
